// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, FSM state encoding and default data width
package alu_pkg;
   localparam int WIDTH = 8;
   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_ADD  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_ZERO = 3'b111;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH register file, two operand read ports, a debug read port, one write port
module alu_regfile #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    ra_addr,
   output logic [WIDTH-1:0] ra_data,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] rb_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [NREG];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end
   assign ra_data = mem[ra_addr];
   assign rb_data = mem[rb_addr];
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file commands to an external combinational ALU and writes results back
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int NREG  = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [2:0]       cmd_opcode,
   input  logic [AW-1:0]    cmd_dst,
   input  logic [AW-1:0]    cmd_srca,
   input  logic [AW-1:0]    cmd_srcb,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [AW-1:0]    res_dst,
   output logic             res_zero,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   state_t           state;
   logic [AW-1:0]    dst_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] ra_data, rb_data, wdata;
   logic [AW-1:0]    waddr;
   logic             accept, we, in_wb;
   assign cmd_ready = state == ST_IDLE;
   assign accept    = cmd_valid && cmd_ready;
   assign in_wb     = state == ST_WB;
   // loads and ALU writebacks never collide: no command is accepted while in WB
   assign we    = (accept && cmd_load) || in_wb;
   assign waddr = in_wb ? dst_q : cmd_dst;
   assign wdata = in_wb ? result_q : cmd_imm;
   alu_regfile #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .ra_addr (cmd_srca),
      .ra_data (ra_data),
      .rb_addr (cmd_srcb),
      .rb_data (rb_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         dst_q     <= '0;
         result_q  <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_dst   <= '0;
         res_zero  <= 1'b0;
      end else begin
         res_valid <= we;
         if (we) begin
            res_data <= wdata;
            res_dst  <= waddr;
            res_zero <= wdata == '0;
         end
         case (state)
            ST_IDLE: if (accept && !cmd_load) begin
               alu_a  <= ra_data;
               alu_b  <= rb_data;
               alu_op <= cmd_opcode;
               dst_q  <= cmd_dst;
               state  <= ST_EXEC;
            end
            ST_EXEC: begin
               result_q <= alu_res;
               state    <= ST_WB;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed test of alu_issue_ctrl with a stand-in ALU and a cycle-level behavioural model
module tb_alu_issue_ctrl;
   import alu_pkg::*;
   logic       clk = 0, rst = 1;
   logic       cmd_valid = 0, cmd_ready, cmd_load = 0;
   logic [2:0] cmd_opcode = 0, alu_op;
   logic [1:0] cmd_dst = 0, cmd_srca = 0, cmd_srcb = 0, res_dst, rd_addr = 0;
   logic [7:0] cmd_imm = 0, alu_a, alu_b, alu_res, res_data, rd_data;
   logic       res_valid, res_zero;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_opcode(cmd_opcode), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
      .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
      .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst), .res_zero(res_zero),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         OP_NOT: return ~a;
         OP_OR:  return a | b;
         OP_XOR: return a ^ b;
         OP_AND: return a & b;
         OP_MUL: return a * b;
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         default: return 8'h00;
      endcase
   endfunction
   always_comb alu_res = alu_f(alu_op, alu_a, alu_b);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask
   // model: registers as an array, an in-flight ALU op as (cycles left, dst, value)
   logic [7:0] m_regs [4];
   logic [7:0] m_a = 0, m_b = 0, m_data = 0, p_val = 0;
   logic [2:0] m_op = 0;
   logic [1:0] m_dst = 0, p_dst = 0;
   logic       m_valid = 0, m_zero = 0, m_acc = 0, started = 0;
   int         busy = 0;
   always @(posedge clk) begin
      m_acc = 0;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 0;
         busy = 0; m_a = 0; m_b = 0; m_op = 0;
         m_valid = 0; m_data = 0; m_dst = 0; m_zero = 0;
      end else begin
         m_valid = 0;
         if (busy != 0) begin
            busy--;
            if (busy == 0) begin
               m_regs[p_dst] = p_val;
               m_valid = 1; m_data = p_val; m_dst = p_dst; m_zero = p_val == 0;
            end
         end else if (cmd_valid) begin
            m_acc = 1;
            if (cmd_load) begin
               m_regs[cmd_dst] = cmd_imm;
               m_valid = 1; m_data = cmd_imm; m_dst = cmd_dst; m_zero = cmd_imm == 0;
            end else begin
               m_a = m_regs[cmd_srca]; m_b = m_regs[cmd_srcb]; m_op = cmd_opcode;
               p_dst = cmd_dst; p_val = alu_f(cmd_opcode, m_a, m_b); busy = 2;
            end
         end
      end
      started = 1;
   end
   always @(negedge clk) begin
      if (started) begin
         chk("cmd_ready", cmd_ready, busy == 0);
         chk("res_valid", res_valid, m_valid);
         chk("res_data", res_data, m_data);
         chk("res_dst", res_dst, m_dst);
         chk("res_zero", res_zero, m_zero);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_op", alu_op, m_op);
         chk("rd_data", rd_data, m_regs[rd_addr]);
      end
   end
   task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [7:0] imm, output int n);
      cmd_valid = 1; cmd_load = ld; cmd_opcode = op; cmd_dst = d; cmd_srca = a; cmd_srcb = b; cmd_imm = imm;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n++;
         if (m_acc) break;
      end
      if (!m_acc) chk("accept_timeout", 0, 1);
      cmd_valid = 0;
   endtask
   task automatic load(input logic [1:0] d, input logic [7:0] imm);
      int n;
      send(1, 0, d, 0, 0, imm, n);
      chk("load_pulse", res_valid, 1);
      chk("load_data", res_data, imm);
   endtask
   task automatic op3(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b,
                      input logic [7:0] exp);
      int n;
      send(0, op, d, a, b, 0, n);
      chk("op_early_e0", res_valid, 0);
      @(posedge clk); #1;
      chk("op_early_e1", res_valid, 0);
      @(posedge clk); #1;
      chk("op_valid", res_valid, 1);
      chk("op_data", res_data, exp);
      chk("op_zero", res_zero, exp == 0);
      chk("op_dst", res_dst, d);
   endtask
   logic [7:0] tbl [8] = '{8'hC3, 8'hBD, 8'h99, 8'h24, 8'hAC, 8'hE1, 8'h97, 8'h00};
   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); #1;
         chk("reset_reg", rd_data, 0);
      end
      chk("reset_valid", res_valid, 0);
      chk("reset_ready", cmd_ready, 1);
      load(0, 8'h0F);
      load(1, 8'hF0);
      op3(OP_ADD, 2, 0, 1, 8'hFF);
      rd_addr = 2; @(posedge clk); #1;
      chk("reg2_ff", rd_data, 8'hFF);
      load(0, 8'hC8);
      load(1, 8'h64);
      op3(OP_ADD, 3, 0, 1, 8'h2C);
      op3(OP_SUB, 3, 1, 0, 8'h9C);
      load(0, 8'h10);
      load(1, 8'h10);
      op3(OP_MUL, 2, 0, 1, 8'h00);
      load(0, 8'h3C);
      load(1, 8'hA5);
      for (int i = 0; i < 8; i++) op3(3'(i), 2, 0, 1, tbl[i]);
      // second command held valid through EXEC/WB, accepted in the res_valid cycle
      send(0, OP_ADD, 2, 0, 1, 0, n);
      send(0, OP_ADD, 3, 2, 0, 0, n);
      chk("held_wait", n, 3);
      repeat (2) @(posedge clk);
      #1 chk("held_data", res_data, 8'h1D);
      op3(OP_ADD, 1, 1, 1, 8'h4A);
      load(3, 8'h55);
      send(0, OP_ADD, 3, 0, 1, 0, n);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      rd_addr = 3; #1;
      chk("rst_mid_valid", res_valid, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      chk("rst_mid_reg3", rd_data, 0);
      repeat (3) @(posedge clk);
      #1 chk("rst_mid_nowb", res_valid, 0);
      chk("rst_mid_reg3_late", rd_data, 0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
